// File: rtl/rename_unit_pkg.sv
// Shared sizing helpers and index types for the rename stage.
package rename_unit_pkg;

  localparam int unsigned ARCH_REGS_DEF = 32'd8;
  localparam int unsigned PHYS_REGS_DEF = 32'd16;
  localparam int unsigned N_SRC_DEF     = 32'd2;

  // Bits needed to index n entries; never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

  localparam int unsigned AW_DEF = idx_w(ARCH_REGS_DEF);
  localparam int unsigned PW_DEF = idx_w(PHYS_REGS_DEF);

  typedef logic [AW_DEF-1:0] arch_idx_t;
  typedef logic [PW_DEF-1:0] phys_idx_t;

endpackage

// File: rtl/rename_unit_if.sv
// Decode-side rename request/response bundle plus the retire channel.
interface rename_unit_if #(
  parameter int unsigned ARCH_REGS = rename_unit_pkg::ARCH_REGS_DEF,
  parameter int unsigned PHYS_REGS = rename_unit_pkg::PHYS_REGS_DEF,
  parameter int unsigned N_SRC     = rename_unit_pkg::N_SRC_DEF
);
  import rename_unit_pkg::*;

  localparam int unsigned AW = idx_w(ARCH_REGS);
  localparam int unsigned PW = idx_w(PHYS_REGS);

  logic                  rn_valid;
  logic                  rn_ready;
  logic [N_SRC*AW-1:0]   rn_src_arch;
  logic [N_SRC-1:0]      rn_src_ena;
  logic [AW-1:0]         rn_dst_arch;
  logic                  rn_dst_ena;
  logic [N_SRC*PW-1:0]   rn_src_phys;
  logic [N_SRC-1:0]      rn_src_ena_o;
  logic [2*PW-1:0]       rn_wbs;
  logic                  ret_valid;
  logic [AW-1:0]         ret_arch;
  logic [PW-1:0]         ret_phys;

  // Decode / retire side drives requests and observes the mapping results.
  modport master (
    output rn_valid, rn_src_arch, rn_src_ena, rn_dst_arch, rn_dst_ena,
    output ret_valid, ret_arch, ret_phys,
    input  rn_ready, rn_src_phys, rn_src_ena_o, rn_wbs
  );

  // Rename unit side.
  modport slave (
    input  rn_valid, rn_src_arch, rn_src_ena, rn_dst_arch, rn_dst_ena,
    input  ret_valid, ret_arch, ret_phys,
    output rn_ready, rn_src_phys, rn_src_ena_o, rn_wbs
  );

endinterface

// File: rtl/rename_unit_lowbit_select.sv
// Lowest-set-bit encoder: returns the index of the lowest set request bit.
module rename_unit_lowbit_select #(
  parameter int unsigned WIDTH = rename_unit_pkg::PHYS_REGS_DEF,
  parameter int unsigned IW    = rename_unit_pkg::idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IW-1:0]    idx,
  output logic             found
);

  // Scan upward and latch the first set bit; idx is 0 when nothing is set.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (req[i] && !found) begin
        idx   = IW'(i);
        found = 1'b1;
      end else begin
        idx   = idx;
        found = found;
      end
    end
  end

endmodule

// File: rtl/rename_unit.sv
// Register rename stage: speculative map (SRAT), committed map (CRAT),
// a claimed-register bitmap with lowest-index allocation, and a free counter.
module rename_unit #(
  parameter int unsigned ARCH_REGS = rename_unit_pkg::ARCH_REGS_DEF,
  parameter int unsigned PHYS_REGS = rename_unit_pkg::PHYS_REGS_DEF,
  parameter int unsigned N_SRC     = rename_unit_pkg::N_SRC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic                       flush,
  rename_unit_if.slave               rn,
  output logic [$clog2(PHYS_REGS):0] free_count
);
  import rename_unit_pkg::*;

  localparam int unsigned AW = idx_w(ARCH_REGS);
  localparam int unsigned PW = idx_w(PHYS_REGS);
  localparam int unsigned CW = $clog2(PHYS_REGS) + 1;

  logic [PW-1:0]        srat_q [ARCH_REGS];
  logic [PW-1:0]        srat_d [ARCH_REGS];
  logic [PW-1:0]        crat_q [ARCH_REGS];
  logic [PW-1:0]        crat_d [ARCH_REGS];
  logic [PHYS_REGS-1:0] claimed_q;
  logic [PHYS_REGS-1:0] claimed_d;
  logic [CW-1:0]        free_count_q;
  logic [CW-1:0]        free_count_d;

  logic [PW-1:0]        alloc_idx_s;
  logic                 any_free_s;
  logic                 ready_s;
  logic                 alloc_s;

  // Allocation always picks the lowest unclaimed register of the pre-edge bitmap.
  rename_unit_lowbit_select #(
    .WIDTH (PHYS_REGS),
    .IW    (PW)
  ) u_alloc_sel (
    .req   (~claimed_q),
    .idx   (alloc_idx_s),
    .found (any_free_s)
  );

  // Handshake: flush cycles and a full bitmap (for dst requests) block renames.
  always_comb begin
    ready_s = rst & ena & ~flush & (~rn.rn_dst_ena | any_free_s);
    alloc_s = rn.rn_valid & ready_s & rn.rn_dst_ena;
  end

  // Zero-latency lookups from the current SRAT; same-request dst sees old mapping.
  always_comb begin
    rn.rn_ready     = ready_s;
    rn.rn_src_ena_o = rn.rn_src_ena;
    rn.rn_src_phys  = '0;
    for (int s = 0; s < int'(N_SRC); s++) begin
      if (rn.rn_src_ena[s]) begin
        rn.rn_src_phys[s*PW +: PW] = srat_q[rn.rn_src_arch[s*AW +: AW]];
      end else begin
        rn.rn_src_phys[s*PW +: PW] = '0;
      end
    end
    if (rn.rn_dst_ena) begin
      rn.rn_wbs = {srat_q[rn.rn_dst_arch], alloc_idx_s};
    end else begin
      rn.rn_wbs = '0;
    end
  end

  // Next state: allocate, then retire, then flush rebuilds from post-retire CRAT.
  always_comb begin
    srat_d    = srat_q;
    crat_d    = crat_q;
    claimed_d = claimed_q;

    if (alloc_s) begin
      srat_d[rn.rn_dst_arch] = alloc_idx_s;
      claimed_d[alloc_idx_s] = 1'b1;
    end else begin
      claimed_d = claimed_d;
    end

    if (rn.ret_valid) begin
      if (crat_q[rn.ret_arch] != rn.ret_phys) begin
        claimed_d[crat_q[rn.ret_arch]] = 1'b0;
      end else begin
        claimed_d = claimed_d;
      end
      crat_d[rn.ret_arch] = rn.ret_phys;
    end else begin
      crat_d = crat_d;
    end

    if (flush) begin
      srat_d    = crat_d;
      claimed_d = '0;
      for (int a = 0; a < int'(ARCH_REGS); a++) begin
        claimed_d[crat_d[a]] = 1'b1;
      end
    end else begin
      srat_d = srat_d;
    end

    free_count_d = '0;
    for (int p = 0; p < int'(PHYS_REGS); p++) begin
      free_count_d = free_count_d + {{(CW-1){1'b0}}, ~claimed_d[p]};
    end
  end

  // State registers; reset restores identity maps and claims the low registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned a = 0; a < ARCH_REGS; a++) begin
        srat_q[a] <= PW'(a);
        crat_q[a] <= PW'(a);
      end
      for (int unsigned p = 0; p < PHYS_REGS; p++) begin
        claimed_q[p] <= (p < ARCH_REGS) ? 1'b1 : 1'b0;
      end
      free_count_q <= CW'(PHYS_REGS - ARCH_REGS);
    end else begin
      srat_q       <= srat_d;
      crat_q       <= crat_d;
      claimed_q    <= claimed_d;
      free_count_q <= free_count_d;
    end
  end

  assign free_count = free_count_q;

endmodule
